pixel_compositor: RTL and testbench

- Parametrised successor to the single-object pixel generator.
- Merges NUM_LAYERS object layers (snake, food, walls, HUD, …) onto a programmable background using fixed priority, per-layer enable and per-layer blink.
- Two-stage registered pipeline.
- Sits between the per-object "on/color" generators and the HDMI/VGA encoder. Delays vde/hsync/vsync so they stay aligned with RGB.

---
 rtl/pixel_compositor_pkg.sv | 31 +++
 rtl/pixel_compositor_blink_timer.sv | 40 ++++
 rtl/pixel_compositor.sv | 154 +++++++++++++++
 tb/tb_pixel_compositor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_compositor_pkg.sv
// Shared pixel types, colour constants and the layer-slice helper for the compositor.
// Pure declarations: no latency, no flow control.
package pixel_compositor_pkg;

  localparam int CH_W_DEF   = 8;
  localparam int MAX_CH_W   = 16;
  localparam int MAX_LAYERS = 16;

  typedef logic [3*CH_W_DEF-1:0] pixel_t;
  typedef logic [3*MAX_CH_W-1:0] wide_px_t;
  typedef logic [MAX_LAYERS*3*MAX_CH_W-1:0] color_bus_t;

  localparam pixel_t PX_BLACK      = '0;
  localparam pixel_t PX_BG_DEFAULT = 24'hFFFFFF;
  localparam pixel_t PX_SNAKE      = 24'h00FF00;

  function automatic int px_width(input int ch_w);
    return 3 * ch_w;
  endfunction

  // Extracts layer idx from a packed colour bus whose channels are ch_w bits wide.
  function automatic wide_px_t layer_slice(input color_bus_t bus, input int idx, input int ch_w);
    wide_px_t r;
    r = '0;
    for (int b = 0; b < 3*MAX_CH_W; b++) begin
      if (b < 3*ch_w) r[b] = bus[idx*3*ch_w + b];
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_compositor_blink_timer.sv
// Frame-tick blink timer: one-register vsync edge detect, frame counter, blink phase toggle.
// Phase updates one clk after the tick edge; free-running, no backpressure.
module blink_timer #(
  parameter int BLINK_FRAMES = 30,
  parameter bit VSYNC_ACT    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic blink_phase
);

  localparam int CW = $clog2(BLINK_FRAMES + 1);

  logic [CW-1:0] frame_cnt;
  logic          vsync_q;
  logic          tick;

  // A long active vsync yields a single tick because only the entry edge counts.
  assign tick = (vsync == VSYNC_ACT) && (vsync_q != VSYNC_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= ~VSYNC_ACT;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (tick) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// Layer compositor: fixed-priority merge of NUM_LAYERS layers over a background, 2-clk latency, no stalls.
// Optional 50% blend of the winner with the layer beneath under PIXEL_COMPOSITOR_ALPHA_BLEND_EN.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int CH_W         = 8,
  parameter int BLINK_FRAMES = 30,
  parameter bit VSYNC_ACT    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vde_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic [NUM_LAYERS-1:0]          layer_on,
  input  logic [NUM_LAYERS*3*CH_W-1:0]   layer_color,
  input  logic [NUM_LAYERS-1:0]          layer_en,
  input  logic [NUM_LAYERS-1:0]          blink_mask,
  input  logic [NUM_LAYERS-1:0]          layer_alpha,
  input  logic [3*CH_W-1:0]              bg_color,
  output logic [CH_W-1:0]                R,
  output logic [CH_W-1:0]                G,
  output logic [CH_W-1:0]                B,
  output logic                           vde_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic [$clog2(NUM_LAYERS)-1:0]  top_idx,
  output logic                           top_hit
);

  localparam int PX_W = px_width(CH_W);
  localparam int IW   = $clog2(NUM_LAYERS);

  logic blink_phase;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .VSYNC_ACT    (VSYNC_ACT)
  ) u_blink (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync_in),
    .blink_phase (blink_phase)
  );

  logic [NUM_LAYERS-1:0]        s1_vis;
  logic [NUM_LAYERS*PX_W-1:0]   s1_color;
  logic [PX_W-1:0]              s1_bg;
  logic [NUM_LAYERS-1:0]        s1_alpha;
  logic                         s1_vde, s1_hs, s1_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vis   <= '0;
      s1_color <= '0;
      s1_bg    <= '0;
      s1_alpha <= '0;
      s1_vde   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
    end else begin
      s1_vis   <= layer_on & layer_en & ~(blink_mask & {NUM_LAYERS{blink_phase}});
      s1_color <= layer_color;
      s1_bg    <= bg_color;
`ifdef PIXEL_COMPOSITOR_ALPHA_BLEND_EN
      s1_alpha <= layer_alpha;
`else
      s1_alpha <= '0;
`endif
      s1_vde   <= vde_in;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
    end
  end

`ifndef PIXEL_COMPOSITOR_ALPHA_BLEND_EN
  logic unused_alpha;
  assign unused_alpha = ^{layer_alpha, s1_alpha};
`endif

  logic [PX_W-1:0] win_col, under_col, mix_col, col_i;
  logic [IW-1:0]   win_idx;
  logic            win_found, win_alpha;
  color_bus_t      color_bus;

  assign color_bus = color_bus_t'(s1_color);

  // Walk from lowest priority upward: each newly visible layer demotes the previous winner to "under".
  always_comb begin
    win_found = 1'b0;
    win_alpha = 1'b0;
    win_idx   = '0;
    win_col   = s1_bg;
    under_col = s1_bg;
    col_i     = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      col_i = PX_W'(layer_slice(color_bus, i, CH_W));
      if (s1_vis[i]) begin
        under_col = win_col;
        win_col   = col_i;
        win_idx   = IW'(i);
        win_alpha = s1_alpha[i];
        win_found = 1'b1;
      end
    end
  end

`ifdef PIXEL_COMPOSITOR_ALPHA_BLEND_EN
  logic [CH_W:0] ch_sum [3];
  always_comb begin
    mix_col = win_col;
    for (int c = 0; c < 3; c++) begin
      ch_sum[c] = {1'b0, win_col[c*CH_W +: CH_W]} + {1'b0, under_col[c*CH_W +: CH_W]};
      if (win_found && win_alpha) mix_col[c*CH_W +: CH_W] = ch_sum[c][CH_W:1];
    end
  end
`else
  logic unused_under;
  assign unused_under = ^{under_col, win_alpha};
  assign mix_col      = win_col;
`endif

  logic [PX_W-1:0] pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q     <= '0;
      top_idx   <= '0;
      top_hit   <= 1'b0;
      vde_out   <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      vde_out   <= s1_vde;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      if (!s1_vde) begin
        pix_q   <= '0;
        top_idx <= '0;
        top_hit <= 1'b0;
      end else begin
        pix_q   <= mix_col;
        top_idx <= win_found ? win_idx : '0;
        top_hit <= win_found;
      end
    end
  end

  assign R = pix_q[3*CH_W-1 -: CH_W];
  assign G = pix_q[2*CH_W-1 -: CH_W];
  assign B = pix_q[CH_W-1   -: CH_W];

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed and randomized bench for pixel_compositor with a frame-count-based reference model.
module tb_pixel_compositor;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vde_in, hsync_in, vsync_in;
  logic [3:0]  layer_on, layer_en, blink_mask, layer_alpha;
  logic [95:0] layer_color;
  logic [23:0] bg_color;
  logic [7:0]  R, G, B;
  logic        vde_out, hsync_out, vsync_out, top_hit;
  logic [1:0]  top_idx;

  int n_checks = 0;
  int n_err    = 0;
  int m_ticks  = 0;
  bit m_prev_vs = 1'b0;
  logic [29:0] q[$];

  always #5 clk = ~clk;

  pixel_compositor #(
    .NUM_LAYERS (4), .CH_W (8), .BLINK_FRAMES (BF), .VSYNC_ACT (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .vde_in (vde_in), .hsync_in (hsync_in), .vsync_in (vsync_in),
    .layer_on (layer_on), .layer_color (layer_color), .layer_en (layer_en),
    .blink_mask (blink_mask), .layer_alpha (layer_alpha), .bg_color (bg_color),
    .R (R), .G (G), .B (B), .vde_out (vde_out), .hsync_out (hsync_out), .vsync_out (vsync_out),
    .top_idx (top_idx), .top_hit (top_hit)
  );

  // Blink phase follows directly from the number of frame ticks seen since reset.
  function automatic logic [29:0] model();
    logic [23:0] px, under, top;
    logic [3:0]  vis;
    bit          ph, found;
    int          idx;
    ph    = ((m_ticks / BF) % 2) == 1;
    vis   = layer_on & layer_en & ~(blink_mask & {4{ph}});
    found = 1'b0;
    idx   = 0;
    if (!vde_in) return {24'h0, 1'b0, hsync_in, vsync_in, 2'd0, 1'b0};
    for (int i = 0; i < 4; i++) if (vis[i]) begin idx = i; found = 1'b1; break; end
    px = found ? layer_color[idx*24 +: 24] : bg_color;
`ifdef PIXEL_COMPOSITOR_ALPHA_BLEND_EN
    if (found && layer_alpha[idx]) begin
      top   = px;
      under = bg_color;
      for (int j = idx + 1; j < 4; j++) if (vis[j]) begin under = layer_color[j*24 +: 24]; break; end
      for (int c = 0; c < 3; c++) px[c*8 +: 8] = 8'((int'(top[c*8 +: 8]) + int'(under[c*8 +: 8])) / 2);
    end
`endif
    return {px, 1'b1, hsync_in, vsync_in, 2'(idx), found};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [29:0] e;
    q.push_back(model());
    if (vsync_in && !m_prev_vs) m_ticks++;
    m_prev_vs = vsync_in;
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("pipe", {2'b0, R, G, B, vde_out, hsync_out, vsync_out, top_idx, top_hit}, {2'b0, e});
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic restart_model();
    q.delete();
    q.push_back(30'h0);
    m_ticks   = 0;
    m_prev_vs = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {vde_in, hsync_in, vsync_in} = 3'b000;
    layer_on = '0; layer_en = '0; blink_mask = '0; layer_alpha = '0;
    layer_color = '0; bg_color = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {R, G, B, vde_out, top_hit}, 32'h0);
    rst = 1'b0;
    restart_model();

    // Background only
    bg_color = 24'hFFFFFF; vde_in = 1'b1; layer_en = 4'hF;
    run(3);
    chk("bg_white", {R, G, B}, 32'hFFFFFF);
    chk("bg_nohit", top_hit, 0);

    // Priority among two visible layers
    layer_on = 4'b0110;
    layer_color = {24'h0, 24'hFF0000, 24'h00FF00, 24'h123456};
    run(3);
    chk("l1_rgb", {R, G, B}, 32'h00FF00);
    chk("l1_idx", {top_hit, top_idx}, 32'h5);

    // Disabled layer 0 loses to layer 1
    layer_on = 4'b0011; layer_en = 4'b1110;
    run(3);
    chk("en_idx", top_idx, 1);
    vde_in = 1'b0;
    run(3);
    chk("vde0_rgb", {R, G, B, vde_out}, 32'h0);

    // Blink: layer 0 blue with blink_mask, BF = 2
    layer_en = 4'hF; layer_on = 4'b0001; blink_mask = 4'b0001;
    layer_color = {72'h0, 24'h0000FF}; bg_color = 24'hFFFFFF; vde_in = 1'b1;
    run(3);
    chk("blink_pre", {R, G, B}, 32'h0000FF);
    for (int f = 0; f < 6; f++) begin
      vde_in = 1'b0; vsync_in = 1'b1;
      run(f == 2 ? 100 : 3);
      vsync_in = 1'b0; vde_in = 1'b1;
      run(6);
      chk("blink_frame", {R, G, B}, (((f + 1) / BF) % 2) ? 32'hFFFFFF : 32'h0000FF);
    end

    // Alpha blend request
    blink_mask = '0; layer_on = 4'b0001; layer_alpha = 4'b0001;
    layer_color = {72'h0, 24'hFF0000}; bg_color = 24'h0000FF;
    run(3);
`ifdef PIXEL_COMPOSITOR_ALPHA_BLEND_EN
    chk("alpha_rgb", {R, G, B}, 32'h7F007F);
`else
    chk("alpha_rgb", {R, G, B}, 32'hFF0000);
`endif

    // Randomized pixels, syncs and frame ticks
    for (int k = 0; k < 600; k++) begin
      vde_in      = ($urandom_range(0, 7) != 0);
      hsync_in    = 1'($urandom);
      if ($urandom_range(0, 7) == 0) vsync_in = ~vsync_in;
      layer_on    = 4'($urandom);
      layer_en    = 4'($urandom);
      blink_mask  = 4'($urandom);
      layer_alpha = 4'($urandom);
      layer_color = {$urandom, $urandom, $urandom};
      bg_color    = 24'($urandom);
      if ($urandom_range(0, 3) == 0) layer_on = 4'hF;
      cycle();
    end

    // Reset mid-line while layer 1 is shown
    {vde_in, hsync_in, vsync_in} = 3'b100;
    layer_on = 4'b0010; layer_en = 4'hF; blink_mask = '0; layer_alpha = '0;
    layer_color = {48'h0, 24'h00FF00, 24'h0};
    run(4);
    chk("pre_rst", {R, G, B}, 32'h00FF00);
    blink_mask = 4'b0010;
    rst = 1'b1;
    #1;
    chk("rst_async", {R, G, B, vde_out, top_hit, top_idx}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();
    run(3);
    chk("post_rst", {R, G, B}, 32'h00FF00);
    chk("post_rst_idx", {top_hit, top_idx}, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
